// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared 4x4 multiplier controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   Contents: FSM state encoding, operand and product widths.
package mult_share_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/multiply.sv
// Unsigned OP_W x OP_W array multiplier, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
//   Ports: a, b (OP_W operands) -> p (PROD_W product).
module multiply
  import mult_share_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  // Sum of shifted partial products, one row per bit of b.
  always_comb begin
    p = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) p = p + (PROD_W'(a) << i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
// Latency: 0 cycles.
// Backpressure: none; caller masks req when it cannot accept.
//   Ports: req (NREQ), ptr (ID_W) -> gnt (one-hot NREQ), idx (ID_W), any.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one 4x4 multiplier among NREQ requesters with round-robin arbitration.
// Latency: accept edge, then product registered on the next edge; 1 result per 3 cycles max.
// Backpressure: response held stable while rsp_ready=0; no new accept until back in S_IDLE.
//   Ports: clk, rst (sync, active-high); req_valid/req_a/req_b in, req_ready out;
//   rsp_valid/rsp_data/rsp_id out, rsp_ready in; busy out.
//   MULT_SHARE_STATS_EN: adds parameter CNT_W and output grant_cnt (saturating per-requester accepts).
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
`ifdef MULT_SHARE_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [PROD_W-1:0]    rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [PROD_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              accept;
  logic [PROD_W-1:0] mul_p;

  // Requests are only visible to the arbiter in S_IDLE and outside reset,
  // so req_ready can never advertise a handshake that will not happen.
  assign arb_req = req_valid & {NREQ{(state_q == S_IDLE) && !rst}};

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (accept)
  );

  // Datapath sees only registered operands; requesters may change inputs after accept.
  multiply u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d   = req_a[OP_W*int'(gnt_idx) +: OP_W];
          op_b_d   = req_b[OP_W*int'(gnt_idx) +: OP_W];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        rsp_data_d = mul_p;
        rsp_id_d   = id_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MULT_SHARE_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating: an all-ones counter stays put.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && gnt[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a spec-level reference model.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls of 0..5 cycles.
module tb_mult_share_ctrl;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [4*NREQ-1:0]    req_a;
  logic [4*NREQ-1:0]    req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_ready;
  logic                 busy;

  always #5 clk = ~clk;

`ifdef MULT_SHARE_STATS_EN
  localparam int CNT_W = 2;
  logic [NREQ*CNT_W-1:0] grant_cnt;
  mult_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy), .grant_cnt(grant_cnt)
  );
`else
  mult_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );
`endif

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  // Spec rule: first valid requester scanning upward from ptr with wrap; -1 if none.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    model_ptr = 0;
  endtask

  // Drives one full transaction with a nonzero valid vector and checks every phase.
  task automatic run_txn(input logic [NREQ-1:0] vld, input logic [15:0] a,
                         input logic [15:0] b, input int stall);
    int g;
    int ng;
    int ea;
    int eb;
    logic [7:0] ep;
    logic [NREQ-1:0] er;
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    #1;
    g  = model_grant(vld, model_ptr);
    er = NREQ'(1) << g;
    ea = int'(a >> (4 * g)) & 15;
    eb = int'(b >> (4 * g)) & 15;
    ep = 8'(ea * eb);
    model_ptr = (g + 1) % NREQ;
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, er);
    end
    @(posedge clk);
    #1;
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL calc_phase: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0000",
               rsp_valid, busy, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== ep || rsp_id !== ID_W'(g)) begin
      errors++;
      $display("FAIL response: valid=%b data=%0d id=%0d expected 1 %0d %0d",
               rsp_valid, rsp_data, rsp_id, ep, g);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ep || rsp_id !== ID_W'(g) || req_ready !== '0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b data=%0d id=%0d ready=%b expected 1 %0d %0d 0000",
                 rsp_valid, rsp_data, rsp_id, req_ready, ep, g);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    ng = model_grant(vld, model_ptr);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== (NREQ'(1) << ng)) begin
      errors++;
      $display("FAIL after_handshake: valid=%b busy=%b ready=%b expected 0 0 %b",
               rsp_valid, busy, req_ready, NREQ'(1) << ng);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_data !== 8'd0 ||
        rsp_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b data=%0d id=%0d busy=%b expected all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, busy);
    end
  endtask

  task automatic test_single();
    run_txn(4'b0001, 16'h0007, 16'h0009, 0);
    checks++;
    if (rsp_data !== 8'd63 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single: data=%0d id=%0d expected 63 0", rsp_data, rsp_id);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(4'hF, 16'($urandom), 16'($urandom), 0);
      checks++;
      if (rsp_id !== ID_W'(i % NREQ)) begin
        errors++;
        $display("FAIL rr_order: txn %0d id=%0d expected %0d", i, rsp_id, i % NREQ);
      end
    end
  endtask

  task automatic test_backpressure();
    run_txn(4'b1010, 16'hFFFF, 16'hFFFF, 5);
    checks++;
    if (rsp_data !== 8'd225) begin
      errors++;
      $display("FAIL backpressure: data=%0d expected 225", rsp_data);
    end
  endtask

  task automatic test_boundaries();
    run_txn(4'($urandom_range(1, 15)), 16'h0000, 16'hFFFF, 0);
    checks++;
    if (rsp_data !== 8'd0) begin
      errors++;
      $display("FAIL zero_operand: data=%0d expected 0", rsp_data);
    end
    run_txn(4'($urandom_range(1, 15)), 16'hFFFF, 16'h1111, 1);
    checks++;
    if (rsp_data !== 8'd15) begin
      errors++;
      $display("FAIL unit_operand: data=%0d expected 15", rsp_data);
    end
    for (int n = 0; n < 500; n++) begin
      run_txn(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_drop();
    req_valid = 4'b1000;
    req_valid = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_request: ready=%b busy=%b valid=%b expected 0 0 0",
               req_ready, busy, rsp_valid);
    end
    run_txn(4'b0110, 16'($urandom), 16'($urandom), 0);
  endtask

  task automatic test_reset_mid();
    req_valid = 4'hF;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept: busy=%b expected 1", busy);
    end
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst       = 1'b0;
    model_ptr = 0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b data=%0d id=%0d expected 0 0 0 0",
               rsp_valid, busy, rsp_data, rsp_id);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_rsp: valid=%b expected 0", rsp_valid);
      end
    end
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ptr_after_reset: ready=%b expected 0001", req_ready);
    end
    run_txn(4'hF, 16'($urandom), 16'($urandom), 0);
  endtask

`ifdef MULT_SHARE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) run_txn(4'b0100, 16'($urandom), 16'($urandom), 0);
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (grant_cnt[i*CNT_W +: CNT_W] !== ((i == 2) ? CNT_W'(3) : CNT_W'(0))) begin
        errors++;
        $display("FAIL grant_cnt[%0d]: got %0d expected %0d", i,
                 grant_cnt[i*CNT_W +: CNT_W], (i == 2) ? 3 : 0);
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_boundaries();
    test_drop();
    test_reset_mid();
`ifdef MULT_SHARE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
